ava_alu_slave: RTL and testbench

- Avalon-MM slave ALU that sits directly downstream of the team's Avalon master bus-functional model.
- Exposes operand, control, result and status registers.
- Runs single-cycle logic and arithmetic ops and a 32-cycle iterative multiply.
- Uses slave_waitrequest to stall accesses that cannot complete yet, so the master's read and write tasks see a standard handshake.

---
 rtl/ava_alu_slave_if.sv | 21 ++
 rtl/ava_alu_slave.sv | 240 ++++++++++++++++++++++++
 tb/tb_ava_alu_slave.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ava_alu_slave_if.sv
// Avalon-MM slave bus bundle for the ALU register block.
// The master modport is used by whoever drives commands, the slave modport by the ALU.
interface ava_alu_slave_if;
  logic [4:0]  slave_address;
  logic        slave_write;
  logic        slave_read;
  logic [3:0]  slave_byteenable;
  logic [31:0] slave_writedata;
  logic [31:0] slave_readdata;
  logic        slave_waitrequest;

  modport master (
    output slave_address, slave_write, slave_read, slave_byteenable, slave_writedata,
    input  slave_readdata, slave_waitrequest
  );

  modport slave (
    input  slave_address, slave_write, slave_read, slave_byteenable, slave_writedata,
    output slave_readdata, slave_waitrequest
  );
endinterface

// File: rtl/ava_alu_slave.sv
// Avalon-MM slave ALU: operand/control/result/status registers, single-cycle
// logic and arithmetic ops, and an iterative shift-add multiplier.
// Reads always take one wait state (registered readdata); writes and RESULT
// reads stall with waitrequest while an operation is in flight.
module ava_alu_slave #(
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  ava_alu_slave_if.slave  bus,
  output logic            irq
);

  localparam int CNT_W = $clog2(MUL_CYCLES);

  localparam logic [2:0] IDX_OPA    = 3'd0;
  localparam logic [2:0] IDX_OPB    = 3'd1;
  localparam logic [2:0] IDX_CTRL   = 3'd2;
  localparam logic [2:0] IDX_RESULT = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      opa_q, opb_q, result_q, readdata_q;
  logic [3:0]       opcode_q;
  logic             ie_q, done_q, zero_q, carry_q, ovf_q;
  logic [31:0]      work_a_q, work_b_q, acc_q;
  logic [3:0]       work_op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rd_pending_q;

  logic [2:0]  reg_idx;
  logic        busy, wr_accept, start;
  logic        rd_capture, rd_complete, result_read;
  logic        finish_exec, finish_mul;
  logic [31:0] rd_mux;
  logic [31:0] alu_result;
  logic        alu_carry, alu_ovf;
  logic [32:0] sum_ext;
  logic [31:0] diff;
  logic [31:0] acc_next;
  logic        unused_addr_bits;

  assign reg_idx          = bus.slave_address[4:2];
  assign unused_addr_bits = ^bus.slave_address[1:0];

  assign busy        = (state_q != IDLE);
  assign wr_accept   = bus.slave_write & ~busy;
  assign start       = wr_accept & (reg_idx == IDX_CTRL) & bus.slave_byteenable[0]
                       & bus.slave_writedata[4];
  assign rd_capture  = bus.slave_read & ~rd_pending_q & ((reg_idx != IDX_RESULT) | ~busy);
  assign rd_complete = bus.slave_read & rd_pending_q;
  assign result_read = rd_complete & (reg_idx == IDX_RESULT);
  assign finish_exec = (state_q == EXEC);
  assign finish_mul  = (state_q == MUL) && (cnt_q == '0);
  assign acc_next    = acc_q + (work_b_q[0] ? work_a_q : 32'd0);

  assign irq                = done_q & ie_q;
  assign bus.slave_readdata = readdata_q;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

  // Stall writes while busy; stall every read for its first cycle so readdata can be registered.
  always_comb begin
    bus.slave_waitrequest = 1'b0;
    if (!reset_n) begin
      bus.slave_waitrequest = 1'b0;
    end else if (bus.slave_write) begin
      bus.slave_waitrequest = busy;
    end else if (bus.slave_read) begin
      bus.slave_waitrequest = ~rd_pending_q;
    end
  end

  // Single-cycle ALU working only from the operands latched at START.
  always_comb begin
    alu_result = 32'd0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    sum_ext    = {1'b0, work_a_q} + {1'b0, work_b_q};
    diff       = work_a_q - work_b_q;
    case (work_op_q)
      OP_ADD: begin
        alu_result = sum_ext[31:0];
        alu_carry  = sum_ext[32];
        alu_ovf    = (work_a_q[31] == work_b_q[31]) && (sum_ext[31] != work_a_q[31]);
      end
      OP_SUB: begin
        alu_result = diff;
        alu_carry  = (work_a_q < work_b_q);
        alu_ovf    = (work_a_q[31] != work_b_q[31]) && (diff[31] != work_a_q[31]);
      end
      OP_AND:  alu_result = work_a_q & work_b_q;
      OP_OR:   alu_result = work_a_q | work_b_q;
      OP_XOR:  alu_result = work_a_q ^ work_b_q;
      OP_SLL:  alu_result = work_a_q << work_b_q[4:0];
      OP_SRL:  alu_result = work_a_q >> work_b_q[4:0];
      default: alu_result = 32'd0;
    endcase
  end

  // Read data selection for the addressed register; unmapped indices read zero.
  always_comb begin
    rd_mux = 32'd0;
    case (reg_idx)
      IDX_OPA:    rd_mux = opa_q;
      IDX_OPB:    rd_mux = opb_q;
      IDX_CTRL:   rd_mux = {23'd0, ie_q, 3'd0, 1'b0, opcode_q};
      IDX_RESULT: rd_mux = result_q;
      IDX_STATUS: rd_mux = {27'd0, ovf_q, carry_q, zero_q, done_q, busy};
      default:    rd_mux = 32'd0;
    endcase
  end

  // Next-state logic: launch on START, one EXEC cycle, or MUL until the counter runs out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (bus.slave_writedata[3:0] == OP_MUL) ? MUL : EXEC;
      end
      EXEC:    state_d = IDLE;
      MUL:     if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Host-visible operand and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      opcode_q <= 4'd0;
      ie_q     <= 1'b0;
    end else if (wr_accept) begin
      case (reg_idx)
        IDX_OPA: opa_q <= merge_bytes(opa_q, bus.slave_writedata, bus.slave_byteenable);
        IDX_OPB: opb_q <= merge_bytes(opb_q, bus.slave_writedata, bus.slave_byteenable);
        IDX_CTRL: begin
          if (bus.slave_byteenable[0]) opcode_q <= bus.slave_writedata[3:0];
          if (bus.slave_byteenable[1]) ie_q     <= bus.slave_writedata[8];
        end
        default: ;
      endcase
    end
  end

  // Working operands latched at START, then shifted each multiply iteration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work_a_q  <= 32'd0;
      work_b_q  <= 32'd0;
      work_op_q <= 4'd0;
      acc_q     <= 32'd0;
      cnt_q     <= '0;
    end else if (start) begin
      work_a_q  <= opa_q;
      work_b_q  <= opb_q;
      work_op_q <= bus.slave_writedata[3:0];
      acc_q     <= 32'd0;
      cnt_q     <= CNT_W'(MUL_CYCLES - 1);
    end else if (state_q == MUL) begin
      acc_q    <= acc_next;
      work_a_q <= work_a_q << 1;
      work_b_q <= work_b_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
    end
  end

  // Result, flags and sticky DONE; completion wins over any clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= 32'd0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (finish_exec) begin
        result_q <= alu_result;
        zero_q   <= (alu_result == 32'd0);
        carry_q  <= alu_carry;
        ovf_q    <= alu_ovf;
      end else if (finish_mul) begin
        result_q <= acc_next;
        zero_q   <= (acc_next == 32'd0);
        carry_q  <= 1'b0;
        ovf_q    <= 1'b0;
      end
      if (finish_exec || finish_mul) done_q <= 1'b1;
      else if (start || result_read)  done_q <= 1'b0;
    end
  end

  // Registered read port: capture in the wait cycle, complete in the next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q   <= 32'd0;
      rd_pending_q <= 1'b0;
    end else begin
      if (rd_capture) begin
        readdata_q   <= rd_mux;
        rd_pending_q <= 1'b1;
      end else if (rd_complete || !bus.slave_read) begin
        rd_pending_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ava_alu_slave.sv
// Self-checking bench for ava_alu_slave: table of ALU vectors plus hand-written
// sequences for stalls, byte enables, interrupt and mid-operation reset.
module tb_ava_alu_slave;
  localparam int MUL_CYCLES = 32;

  localparam logic [2:0] OPA = 3'd0, OPB = 3'd1, CTRL = 3'd2, RESULT = 3'd3, STATUS = 3'd4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] result;
    logic [7:0]  flags;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[12];

  ava_alu_slave_if bus();

  ava_alu_slave #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic busWrite(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] be,
                          output int waits);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.slave_address    = {idx, 2'($urandom_range(0, 3))};
    bus.slave_writedata  = data;
    bus.slave_byteenable = be;
    bus.slave_write      = 1'b1;
    waits = 0;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (!bus.slave_waitrequest) begin
        ok = 1'b1;
        break;
      end
      waits++;
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL write_timeout idx %0d: waitrequest 1 after %0d cycles, required 0", idx, waits);
    end
    #1 bus.slave_write = 1'b0;
  endtask

  task automatic busRead(input logic [2:0] idx, output logic [31:0] data, output int waits,
                         output logic irq_seen);
    bit ok;
    ok = 1'b0;
    data = 32'd0;
    irq_seen = 1'b0;
    @(negedge clk);
    bus.slave_address = {idx, 2'($urandom_range(0, 3))};
    bus.slave_read    = 1'b1;
    waits = 0;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (!bus.slave_waitrequest) begin
        ok = 1'b1;
        break;
      end
      waits++;
      @(negedge clk);
    end
    if (ok) begin
      data     = bus.slave_readdata;
      irq_seen = irq;
      @(posedge clk);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL read_timeout idx %0d: waitrequest 1 after %0d cycles, required 0", idx, waits);
    end
    #1 bus.slave_read = 1'b0;
  endtask

  task automatic readExpect(input logic [2:0] idx, input logic [31:0] expected, input string name);
    logic [31:0] d;
    int          w;
    logic        q;
    busRead(idx, d, w, q);
    checkOutput(name, d, expected);
  endtask

  task automatic readResultScoreboard(output int waits, output logic irq_seen);
    logic [31:0] d;
    exp_t        e;
    busRead(RESULT, d, waits, irq_seen);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got result 0x%08h, required a pending entry", d);
    end else begin
      e = sb.pop_front();
      checkOutput({e.name, " result"}, d, e.result);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] d;
    int          w;
    int          polls;
    logic        q;
    busWrite(OPA, v.a, 4'hF, w);
    busWrite(OPB, v.b, 4'hF, w);
    busWrite(CTRL, 32'h10 | {28'd0, v.op}, 4'h1, w);
    sb.push_back('{result: v.result, name: v.name});
    polls = 0;
    do begin
      busRead(STATUS, d, w, q);
      polls++;
    end while (d[0] && polls < 100);
    checkOutput({v.name, " status_done"}, d, {24'd0, v.flags | 8'h02});
    readResultScoreboard(w, q);
    readExpect(STATUS, {24'd0, v.flags}, {v.name, " status_after_read"});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int          w;
    logic        q;

    // ADD/SUB flags: ZERO=0x04, CARRY=0x08, OVF=0x10 (DONE added by applyStimulus)
    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd0, 32'h0000_0000, 8'h0C, "add_carry_zero"};
    vecs[1]  = '{32'h0000_0000, 32'h0000_0001, 4'd1, 32'hFFFF_FFFF, 8'h08, "sub_borrow"};
    vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 4'd0, 32'h8000_0000, 8'h10, "add_ovf"};
    vecs[3]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'h8000_0000, 8'h18, "sub_ovf_borrow"};
    vecs[4]  = '{32'h8000_0000, 32'h8000_0000, 4'd0, 32'h0000_0000, 8'h1C, "add_all_flags"};
    vecs[5]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd2, 32'h00F0_00F0, 8'h00, "and"};
    vecs[6]  = '{32'h1234_0000, 32'h0000_5678, 4'd3, 32'h1234_5678, 8'h00, "or"};
    vecs[7]  = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'd4, 32'h0000_0000, 8'h04, "xor_zero"};
    vecs[8]  = '{32'h0000_000F, 32'hFFFF_FFE4, 4'd5, 32'h0000_00F0, 8'h00, "sll_low5"};
    vecs[9]  = '{32'h8000_0000, 32'h0000_001F, 4'd6, 32'h0000_0001, 8'h00, "srl_31"};
    vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 32'h0000_0001, 8'h00, "mul_wrap"};
    vecs[11] = '{32'h0000_0005, 32'h0000_0006, 4'd9, 32'h0000_0000, 8'h04, "reserved_op"};

    bus.slave_address    = 5'd0;
    bus.slave_write      = 1'b0;
    bus.slave_read       = 1'b0;
    bus.slave_byteenable = 4'h0;
    bus.slave_writedata  = 32'd0;

    // Reset values and one wait state on every register index
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_readdata", bus.slave_readdata, 32'd0);
    checkOutput("reset_waitrequest", {31'd0, bus.slave_waitrequest}, 32'd0);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      busRead(3'(i), d, w, q);
      checkOutput($sformatf("reset_reg%0d", i), d, 32'd0);
      checkOutput($sformatf("reset_reg%0d_waits", i), w, 1);
    end
    checkOutput("idle_irq", {31'd0, irq}, 32'd0);

    // Byte enables on OPA, and a START with only lane 1 enabled must not launch
    busWrite(OPA, 32'hAABB_CCDD, 4'hF, w);
    checkOutput("idle_write_waits", w, 0);
    busWrite(OPA, 32'h1122_3344, 4'h5, w);
    readExpect(OPA, 32'hAA22_CC44, "opa_byteenable");
    busWrite(CTRL, 32'h0000_0010, 4'h2, w);
    readExpect(STATUS, 32'd0, "start_be2_no_launch");
    readExpect(CTRL, 32'd0, "ctrl_be2");

    $display("[TB] running %0d table vectors", $size(vecs));
    for (int i = 0; i < $size(vecs); i++) applyStimulus(vecs[i]);

    // MUL with IE: immediate RESULT read stalls until the op finishes
    busWrite(OPA, 32'h0001_2345, 4'hF, w);
    busWrite(OPB, 32'h0000_0100, 4'hF, w);
    busWrite(CTRL, 32'h0000_0117, 4'h3, w);
    sb.push_back('{result: 32'h0123_4500, name: "mul_stall"});
    readResultScoreboard(w, q);
    checkOutput("mul_stall_waits", w, MUL_CYCLES + 1);
    checkOutput("mul_irq_at_read", {31'd0, q}, 32'd1);
    checkOutput("mul_irq_after_read", {31'd0, irq}, 32'd0);
    readExpect(CTRL, 32'h0000_0107, "ctrl_readback");

    // Operand rewrite during MUL stalls and does not disturb the running op
    busWrite(OPA, 32'h0000_0003, 4'hF, w);
    busWrite(OPB, 32'h0000_0005, 4'hF, w);
    busWrite(CTRL, 32'h0000_0017, 4'h3, w);
    sb.push_back('{result: 32'h0000_000F, name: "mul_rewrite"});
    busRead(STATUS, d, w, q);
    checkOutput("busy_status", d, 32'h0000_0001);
    checkOutput("busy_status_waits", w, 1);
    busWrite(OPA, 32'hFFFF_FFFF, 4'hF, w);
    checkOutput("busy_write_waits", w, MUL_CYCLES - 2);
    readResultScoreboard(w, q);
    readExpect(OPA, 32'hFFFF_FFFF, "opa_rewritten");

    // Reset in the middle of a multiply clears everything at once
    busWrite(CTRL, 32'h0000_0117, 4'h3, w);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_readdata", bus.slave_readdata, 32'd0);
    checkOutput("midreset_waitrequest", {31'd0, bus.slave_waitrequest}, 32'd0);
    checkOutput("midreset_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    readExpect(STATUS, 32'd0, "post_reset_status");
    readExpect(RESULT, 32'd0, "post_reset_result");
    readExpect(OPA, 32'd0, "post_reset_opa");
    readExpect(CTRL, 32'd0, "post_reset_ctrl");

    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
